avr_asm_stream: RTL and testbench



---
 rtl/avr_asm_stream.sv | 191 +++++++++++++++++++
 tb/tb_avr_asm_stream.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/avr_asm_stream.sv
// AVR instruction encoder: turns symbolic instruction requests into 16-bit
// program words and streams them with a running word address over a
// valid/ready handshake. Two-word instructions go out as two beats.
// Illegal requests are consumed, produce no word and pulse err.
module avr_asm_stream #(
  parameter int ADW     = 16,
  parameter int ADR_RST = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_vld,
  output logic           req_rdy,
  input  logic [5:0]     req_op,
  input  logic [4:0]     req_rd,
  input  logic [4:0]     req_rr,
  input  logic [21:0]    req_k,
  input  logic [2:0]     req_b,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [15:0]    out_dat,
  output logic [ADW-1:0] out_adr,
  output logic           out_lst,
  output logic           err,
  output logic [15:0]    cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, HI} state_t;

  state_t      state, nxt;
  logic [15:0] w0, w1, w1_buf;
  logic        two, ill;
  logic        acc, xfer, ld0, ld1;
  logic [3:0]  alu_code;
  logic [3:0]  imm_pfx;
  logic [2:0]  sr_sel;

  // Encoder: word0/word1, two-word flag and illegal flag for the request
  always_comb begin
    w0       = '0;
    w1       = '0;
    two      = 1'b0;
    ill      = 1'b0;
    alu_code = 4'(req_op - 6'd1);
    imm_pfx  = 4'h0;
    sr_sel   = 3'd0;
    case (req_op) inside
      6'd0: w0 = 16'h0000;
      6'd1: begin
        w0  = {8'h01, req_rd[4:1], req_rr[4:1]};
        ill = req_rd[0] | req_rr[0];
      end
      [6'd2:6'd12]:
        w0 = {2'b00, alu_code, req_rr[4], req_rd[4], req_rd[3:0], req_rr[3:0]};
      [6'd13:6'd18]: begin
        case (req_op)
          6'd13:   imm_pfx = 4'h3;
          6'd14:   imm_pfx = 4'h4;
          6'd15:   imm_pfx = 4'h5;
          6'd16:   imm_pfx = 4'h6;
          6'd17:   imm_pfx = 4'h7;
          default: imm_pfx = 4'hE;
        endcase
        w0  = {imm_pfx, req_k[7:4], req_rd[3:0], req_k[3:0]};
        ill = ~req_rd[4] | (|req_k[21:8]);
      end
      [6'd19:6'd25]: begin
        case (req_op)
          6'd19:   sr_sel = 3'd0;
          6'd20:   sr_sel = 3'd1;
          6'd21:   sr_sel = 3'd2;
          6'd22:   sr_sel = 3'd3;
          6'd23:   sr_sel = 3'd5;
          6'd24:   sr_sel = 3'd6;
          default: sr_sel = 3'd7;
        endcase
        w0 = {7'b1001010, req_rd, 1'b0, sr_sel};
      end
      6'd26: w0 = {7'b1001010, req_rd, 4'b1010};
      6'd27: w0 = {7'b1001000, req_rd, 4'b1111};
      6'd28: w0 = {7'b1001001, req_rd, 4'b1111};
      6'd29: begin
        w0  = {5'b10110, req_k[5:4], req_rd, req_k[3:0]};
        ill = |req_k[21:6];
      end
      6'd30: begin
        w0  = {5'b10111, req_k[5:4], req_rd, req_k[3:0]};
        ill = |req_k[21:6];
      end
      6'd31, 6'd32: begin
        w0  = {(req_op == 6'd31) ? 4'hC : 4'hD, req_k[11:0]};
        ill = req_k[21:12] != {10{req_k[11]}};
      end
      6'd33, 6'd34: begin
        w0  = {7'b1001010, req_k[21:17], 2'b11, req_op == 6'd34, req_k[16]};
        w1  = req_k[15:0];
        two = 1'b1;
      end
      6'd35, 6'd36: begin
        w0  = {6'b100100, req_op == 6'd36, req_rd, 4'b0000};
        w1  = req_k[15:0];
        two = 1'b1;
        ill = |req_k[21:16];
      end
      6'd37: w0 = 16'h9508;
      6'd38: w0 = 16'h9518;
      6'd39: w0 = 16'h9588;
      6'd40: w0 = 16'h95A8;
      6'd41: w0 = 16'h9409;
      6'd42: w0 = 16'h9509;
      6'd43, 6'd44: w0 = {8'h94, req_op == 6'd44, req_b, 4'h8};
      6'd45, 6'd46: begin
        w0  = {5'b11110, req_op == 6'd46, req_k[6:0], req_b};
        ill = req_k[21:7] != {15{req_k[6]}};
      end
      6'd47, 6'd48: begin
        w0  = {7'b1001011, req_op == 6'd48, req_k[5:4], req_rd[2:1], req_k[3:0]};
        ill = (req_rd[4:3] != 2'b11) | req_rd[0] | (|req_k[21:6]);
      end
      6'd49, 6'd50: begin
        w0  = {6'b100110, req_op == 6'd50, 1'b0, req_k[4:0], req_b};
        ill = |req_k[21:5];
      end
      6'd51: w0 = {6'b100111, req_rr[4], req_rd[4], req_rd[3:0], req_rr[3:0]};
      default: ill = 1'b1;
    endcase
  end

  assign req_rdy = (state == EMPTY) | ((state == ONE) & out_rdy);
  assign out_vld = (state != EMPTY);
  assign acc     = req_vld & req_rdy;
  assign xfer    = out_vld & out_rdy;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= nxt;
  end

  // Next state and output-register load strobes
  always_comb begin
    nxt = state;
    ld0 = 1'b0;
    ld1 = 1'b0;
    case (state)
      EMPTY, ONE: begin
        if (acc) begin
          if (ill) begin
            nxt = EMPTY;
          end else begin
            ld0 = 1'b1;
            nxt = two ? HI : ONE;
          end
        end else if ((state == ONE) && out_rdy) begin
          nxt = EMPTY;
        end
      end
      HI: begin
        if (out_rdy) begin
          ld1 = 1'b1;
          nxt = ONE;
        end
      end
      default: nxt = EMPTY;
    endcase
  end

  // Output word, address, word1 buffer, error pulse and instruction count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dat <= '0;
      out_lst <= 1'b0;
      out_adr <= ADW'(ADR_RST);
      w1_buf  <= '0;
      err     <= 1'b0;
      cnt     <= '0;
    end else begin
      err <= acc & ill;
      if (xfer) out_adr <= out_adr + ADW'(1);
      if (xfer && out_lst) cnt <= cnt + 16'd1;
      if (ld0) begin
        out_dat <= w0;
        out_lst <= ~two;
        w1_buf  <= w1;
      end else if (ld1) begin
        out_dat <= w1_buf;
        out_lst <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avr_asm_stream.sv
// Directed self-checking bench for avr_asm_stream.
module tb_avr_asm_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic [5:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rr;
  logic [21:0] req_k;
  logic [2:0]  req_b;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] out_dat;
  logic [15:0] out_adr;
  logic        out_lst;
  logic        err;
  logic [15:0] cnt;

  int errors = 0;
  int checks = 0;

  avr_asm_stream #(.ADW(16), .ADR_RST(0)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_rd(req_rd),
    .req_rr(req_rr), .req_k(req_k), .req_b(req_b),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_adr(out_adr),
    .out_lst(out_lst), .err(err), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rr,
                     input logic [21:0] k, input logic [2:0] b);
    req_vld = 1'b1;
    req_op  = op;
    req_rd  = rd;
    req_rr  = rr;
    req_k   = k;
    req_b   = b;
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; out_rdy = 1'b1;
    req_op = '0; req_rd = '0; req_rr = '0; req_k = '0; req_b = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_rdy", req_rdy, 1); chk("rst_vld", out_vld, 0);
    chk("rst_dat", out_dat, 0); chk("rst_adr", out_adr, 0);
    chk("rst_lst", out_lst, 0); chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);
    rst = 1'b0;

    // in r3,0x3F ; mul r31,r16 ; ldi r16,0xFF back to back
    req(6'd29, 5'd3, 5'd0, 22'h3F, 3'd0); step();
    chk("in_dat", out_dat, 16'hB63F); chk("in_adr", out_adr, 0);
    chk("in_lst", out_lst, 1); chk("in_vld", out_vld, 1); chk("in_rdy", req_rdy, 1);
    req(6'd51, 5'd31, 5'd16, 22'h0, 3'd0); step();
    chk("mul_dat", out_dat, 16'h9FF0); chk("mul_adr", out_adr, 1);
    req(6'd18, 5'd16, 5'd0, 22'hFF, 3'd0); step();
    chk("ldi_dat", out_dat, 16'hEF0F); chk("ldi_adr", out_adr, 2);
    chk("ldi_lst", out_lst, 1); chk("ldi_cnt_before", cnt, 2);
    req_vld = 1'b0; step();
    chk("ldi_cnt", cnt, 3); chk("idle_vld", out_vld, 0); chk("idle_adr", out_adr, 3);

    // add r1,r2 then adiw r25:24,1
    req(6'd4, 5'd1, 5'd2, 22'h0, 3'd0); step();
    chk("add_dat", out_dat, 16'h0C12); chk("add_adr", out_adr, 3); chk("add_rdy", req_rdy, 1);
    req(6'd47, 5'd24, 5'd0, 22'h1, 3'd0); step();
    chk("adiw_dat", out_dat, 16'h9601); chk("adiw_adr", out_adr, 4); chk("adiw_cnt", cnt, 4);
    req_vld = 1'b0; step();
    chk("adiw_done_vld", out_vld, 0); chk("adiw_done_cnt", cnt, 5); chk("adiw_done_adr", out_adr, 5);

    // jmp 0x123 with sink stalled for 3 cycles
    out_rdy = 1'b0;
    req(6'd33, 5'd0, 5'd0, 22'h000123, 3'd0); step();
    req_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("jmp_w0_dat", out_dat, 16'h940C); chk("jmp_w0_lst", out_lst, 0);
      chk("jmp_w0_adr", out_adr, 5); chk("jmp_w0_vld", out_vld, 1);
      chk("jmp_hi_rdy", req_rdy, 0);
      step();
    end
    out_rdy = 1'b1;
    #1 chk("jmp_hi_rdy_sink", req_rdy, 0);
    step();
    chk("jmp_w1_dat", out_dat, 16'h0123); chk("jmp_w1_lst", out_lst, 1);
    chk("jmp_w1_adr", out_adr, 6); chk("jmp_w1_cnt", cnt, 5);
    step();
    chk("jmp_done_vld", out_vld, 0); chk("jmp_done_cnt", cnt, 6); chk("jmp_done_adr", out_adr, 7);

    // rjmp boundary cases and illegal operands
    req(6'd31, 5'd0, 5'd0, 22'h3FFFFF, 3'd0); step();
    chk("rjmp_dat", out_dat, 16'hCFFF); chk("rjmp_adr", out_adr, 7); chk("rjmp_err", err, 0);
    req(6'd31, 5'd0, 5'd0, 22'h000800, 3'd0); step();
    chk("rjmp_ill_err", err, 1); chk("rjmp_ill_vld", out_vld, 0);
    chk("rjmp_ill_cnt", cnt, 7); chk("rjmp_ill_adr", out_adr, 8);
    req(6'd18, 5'd5, 5'd0, 22'h00, 3'd0); step();
    chk("ldi_r5_err", err, 1); chk("ldi_r5_vld", out_vld, 0); chk("ldi_r5_cnt", cnt, 7);
    req(6'd49, 5'd0, 5'd0, 22'h20, 3'd1); step();
    chk("cbi_a32_err", err, 1); chk("cbi_a32_vld", out_vld, 0);
    req(6'd52, 5'd0, 5'd0, 22'h0, 3'd0); step();
    chk("op52_err", err, 1); chk("op52_vld", out_vld, 0);
    req_vld = 1'b0; step();
    chk("err_clear", err, 0); chk("err_cnt_kept", cnt, 7);

    // brbc b=1,k=-2 then bclr 7
    req(6'd46, 5'd0, 5'd0, 22'h3FFFFE, 3'd1); step();
    chk("brbc_dat", out_dat, 16'hF7F1); chk("brbc_adr", out_adr, 8);
    req(6'd44, 5'd0, 5'd0, 22'h0, 3'd7); step();
    chk("bclr_dat", out_dat, 16'h94F8); chk("bclr_adr", out_adr, 9); chk("bclr_cnt", cnt, 8);
    req_vld = 1'b0; step();
    chk("bclr_done_cnt", cnt, 9); chk("bclr_done_adr", out_adr, 10);

    // call: word0 transfers, then reset before word1 goes out
    req(6'd34, 5'd0, 5'd0, 22'h000123, 3'd0); step();
    req_vld = 1'b0;
    chk("call_w0_dat", out_dat, 16'h940E); chk("call_w0_lst", out_lst, 0);
    chk("call_w0_adr", out_adr, 10);
    step();
    chk("call_w1_dat", out_dat, 16'h0123); chk("call_w1_adr", out_adr, 11);
    out_rdy = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", out_vld, 0); chk("mid_rst_adr", out_adr, 0);
    chk("mid_rst_cnt", cnt, 0); chk("mid_rst_dat", out_dat, 0);
    chk("mid_rst_lst", out_lst, 0); chk("mid_rst_rdy", req_rdy, 1);
    step();
    rst = 1'b0;
    out_rdy = 1'b1;
    step(); step();
    chk("post_rst_vld", out_vld, 0); chk("post_rst_adr", out_adr, 0); chk("post_rst_cnt", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
